// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory front-end that sits between the main FSM/datapath and a single-port
// ready/valid memory. It selects the address (PC or Result) and issues fetch,
// load and store transactions. It also owns the instruction register, the
// OldPC register and the load data register. Stall holds the main FSM state
// until the access has completed.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   AdrSrc, IRWrite, MemWrite request controls from the main FSM
//   PC, Result, WriteData    address sources and store data
//   Instr, OldPC, Data       captured instruction, its PC, and load data
//   Stall, BusErr            hold request to the FSM, sticky error flag
//   mem_req_*, mem_addr, mem_we, mem_wdata, mem_wstrb   request channel
//   mem_rsp_valid, mem_rdata                            response channel
//
// state  | meaning
// S_IDLE | waiting for a request; it is issued combinationally in this cycle
// S_REQ  | request held on the bus until the memory accepts it
// S_RSP  | read accepted; waiting for read data
// S_DONE | access finished; Stall low for one cycle so the FSM can advance
module mem_access_unit #(
    parameter int               XLEN     = 32,
    parameter int               TIMEOUT  = 255,
    parameter logic [XLEN-1:0]  RESET_IR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            AdrSrc,
    input  logic            IRWrite,
    input  logic            MemWrite,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] Result,
    input  logic [XLEN-1:0] WriteData,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] OldPC,
    output logic [XLEN-1:0] Data,
    output logic            Stall,
    output logic            BusErr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

    localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

    state_t          state_q;
    logic [XLEN-1:0] addr_q;
    logic            we_q;
    logic [XLEN-1:0] wdata_q;
    logic            fetch_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] oldpc_q;
    logic [XLEN-1:0] data_q;
    logic            buserr_q;
    logic            req_valid_q;
    logic [15:0]     cnt_q;
    logic [15:0]     cnt_d;

    logic            is_idle;
    logic            req_any;
    logic            req_store;
    logic [XLEN-1:0] req_addr;
    logic            misaligned;
    logic            issue;
    logic            timed_out;

    // A fetch wins over a simultaneous store, so a store is only a store
    // when IRWrite is low. Any of the three controls counts as a request.
    assign is_idle    = (state_q == S_IDLE);
    assign req_any    = IRWrite | MemWrite | AdrSrc;
    assign req_store  = MemWrite & ~IRWrite;
    assign req_addr   = AdrSrc ? Result : PC;
    assign misaligned = (req_addr[1:0] != 2'b00);
    assign issue      = is_idle & req_any & ~misaligned;

    // The timeout fires in the TIMEOUT-th cycle spent in S_REQ/S_RSP.
    assign cnt_d     = cnt_q + 16'd1;
    assign timed_out = (cnt_d == TO_CNT);

    // In S_IDLE the request goes out in the same cycle it is seen; afterwards
    // the latched copy keeps the bus stable while the access is pending.
    assign mem_req_valid = ~reset & (issue | req_valid_q);
    assign mem_addr      = (is_idle & req_any) ? req_addr  : addr_q;
    assign mem_we        = (is_idle & req_any) ? req_store : we_q;
    assign mem_wdata     = (is_idle & req_any) ? WriteData : wdata_q;
    assign mem_wstrb     = 4'hF;

    assign Stall  = is_idle ? req_any : (state_q != S_DONE);
    assign Instr  = instr_q;
    assign OldPC  = oldpc_q;
    assign Data   = data_q;
    assign BusErr = buserr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            fetch_q     <= 1'b0;
            pc_q        <= '0;
            instr_q     <= RESET_IR;
            oldpc_q     <= '0;
            data_q      <= '0;
            buserr_q    <= 1'b0;
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        addr_q  <= req_addr;
                        we_q    <= req_store;
                        wdata_q <= WriteData;
                        fetch_q <= IRWrite;
                        pc_q    <= PC;
                        // Conflicting fetch+store: the store is dropped.
                        if (IRWrite & MemWrite) begin
                            buserr_q <= 1'b1;
                        end
                        if (misaligned) begin
                            buserr_q <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (mem_req_ready) begin
                            state_q <= req_store ? S_DONE : S_RSP;
                        end else begin
                            req_valid_q <= 1'b1;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (timed_out) begin
                        buserr_q    <= 1'b1;
                        req_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_DONE;
                    end else if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (we_q) begin
                            cnt_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q   <= cnt_d;
                            state_q <= S_RSP;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RSP: begin
                    // A response coinciding with the timeout is discarded.
                    if (timed_out) begin
                        buserr_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end else if (mem_rsp_valid) begin
                        if (fetch_q) begin
                            instr_q <= mem_rdata;
                            oldpc_q <= pc_q;
                        end else begin
                            data_q <= mem_rdata;
                        end
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        AdrSrc;
    logic        IRWrite;
    logic        MemWrite;
    logic [31:0] PC;
    logic [31:0] Result;
    logic [31:0] WriteData;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    logic [31:0] Instr, OldPC, Data, mem_addr, mem_wdata;
    logic        Stall, BusErr, mem_req_valid, mem_we;
    logic [3:0]  mem_wstrb;

    logic [31:0] to_Instr, to_OldPC, to_Data, to_mem_addr, to_mem_wdata;
    logic        to_Stall, to_BusErr, to_mem_req_valid, to_mem_we;
    logic [3:0]  to_mem_wstrb;

    int n_checks = 0;
    int n_err    = 0;
    int hs_cnt   = 0;
    int hs0;

    mem_access_unit u_dut (
        .clk(clk), .reset(reset), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .PC(PC), .Result(Result), .WriteData(WriteData),
        .Instr(Instr), .OldPC(OldPC), .Data(Data), .Stall(Stall),
        .BusErr(BusErr), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.TIMEOUT(4)) u_to (
        .clk(clk), .reset(reset), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .PC(PC), .Result(Result), .WriteData(WriteData),
        .Instr(to_Instr), .OldPC(to_OldPC), .Data(to_Data), .Stall(to_Stall),
        .BusErr(to_BusErr), .mem_req_valid(to_mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(to_mem_addr), .mem_we(to_mem_we),
        .mem_wdata(to_mem_wdata), .mem_wstrb(to_mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Accepted request handshakes on the default instance.
    always @(posedge clk) begin
        if (!reset && mem_req_valid && mem_req_ready) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; AdrSrc = 0; IRWrite = 0; MemWrite = 0;
        PC = 0; Result = 0; WriteData = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;

        // Reset state
        @(negedge clk);
        chk("rst_instr", Instr, 32'h00000013);
        chk("rst_oldpc", OldPC, 32'h0);
        chk("rst_data", Data, 32'h0);
        chk("rst_buserr", {31'b0, BusErr}, 32'h0);
        chk("rst_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_stall", {31'b0, Stall}, 32'h0);

        // 1: fetch from PC=0x40, ready at once, response one cycle later
        @(posedge clk); #1;
        reset = 0; PC = 32'h40; IRWrite = 1; mem_req_ready = 1;
        @(negedge clk);
        chk("t1_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("t1_addr", mem_addr, 32'h40);
        chk("t1_we", {31'b0, mem_we}, 32'h0);
        chk("t1_stall_c0", {31'b0, Stall}, 32'h1);
        @(posedge clk); #1;
        mem_rsp_valid = 1; mem_rdata = 32'h00500093;
        @(negedge clk);
        chk("t1_stall_c1", {31'b0, Stall}, 32'h1);
        chk("t1_valid_rsp", {31'b0, mem_req_valid}, 32'h0);
        @(posedge clk); #1;
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("t1_stall_done", {31'b0, Stall}, 32'h0);
        chk("t1_instr", Instr, 32'h00500093);
        chk("t1_oldpc", OldPC, 32'h40);
        chk("t1_no_reissue", {31'b0, mem_req_valid}, 32'h0);
        @(posedge clk); #1;
        IRWrite = 0; mem_req_ready = 0;

        // 2: load from 0x100 with ready low for 3 cycles
        hs0 = hs_cnt;
        AdrSrc = 1; Result = 32'h100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_valid_hold", {31'b0, mem_req_valid}, 32'h1);
            chk("t2_addr_hold", mem_addr, 32'h100);
            chk("t2_stall_hold", {31'b0, Stall}, 32'h1);
            @(posedge clk); #1;
            Result = 32'h200;
            mem_req_ready = (i == 2);
        end
        mem_rsp_valid = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("t2_valid_rsp", {31'b0, mem_req_valid}, 32'h0);
        chk("t2_stall_rsp", {31'b0, Stall}, 32'h1);
        @(posedge clk); #1;
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("t2_data", Data, 32'hCAFEF00D);
        chk("t2_stall_done", {31'b0, Stall}, 32'h0);
        chk("t2_one_txn", 32'(hs_cnt - hs0), 32'd1);
        @(posedge clk); #1;
        AdrSrc = 0;

        // 3: store DEADBEEF to 0x104, MemWrite held through S_DONE
        hs0 = hs_cnt;
        MemWrite = 1; AdrSrc = 1; Result = 32'h104; WriteData = 32'hDEADBEEF;
        mem_req_ready = 1;
        @(negedge clk);
        chk("t3_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("t3_we", {31'b0, mem_we}, 32'h1);
        chk("t3_wstrb", {28'b0, mem_wstrb}, 32'hF);
        chk("t3_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t3_addr", mem_addr, 32'h104);
        chk("t3_stall", {31'b0, Stall}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_stall_done", {31'b0, Stall}, 32'h0);
        chk("t3_no_reissue", {31'b0, mem_req_valid}, 32'h0);
        @(posedge clk); #1;
        MemWrite = 0; AdrSrc = 0;
        @(negedge clk);
        chk("t3_one_write", 32'(hs_cnt - hs0), 32'd1);

        // 4: misaligned load from 0x102
        @(posedge clk); #1;
        AdrSrc = 1; Result = 32'h102;
        @(negedge clk);
        chk("t4_no_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("t4_stall", {31'b0, Stall}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_buserr", {31'b0, BusErr}, 32'h1);
        chk("t4_stall_done", {31'b0, Stall}, 32'h0);
        chk("t4_data_kept", Data, 32'hCAFEF00D);
        @(posedge clk); #1;
        AdrSrc = 0;

        // 6: reset asserted while a fetch waits in S_REQ
        IRWrite = 1; PC = 32'h80; mem_req_ready = 0;
        @(negedge clk);
        chk("t6_valid_idle", {31'b0, mem_req_valid}, 32'h1);
        @(posedge clk); #1;
        chk("t6_valid_req", {31'b0, mem_req_valid}, 32'h1);
        #1;
        reset = 1; IRWrite = 0; mem_rsp_valid = 1; mem_rdata = 32'hBADBAD00;
        #1;
        chk("t6_valid_rst", {31'b0, mem_req_valid}, 32'h0);
        chk("t6_instr_rst", Instr, 32'h00000013);
        chk("t6_buserr_rst", {31'b0, BusErr}, 32'h0);
        chk("t6_stall_rst", {31'b0, Stall}, 32'h0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("t6_rsp_ignored", Instr, 32'h00000013);
        chk("t6_idle_valid", {31'b0, mem_req_valid}, 32'h0);

        // 5: fetch with no response; TIMEOUT=4 instance aborts
        @(posedge clk); #1;
        mem_rsp_valid = 0; IRWrite = 1; PC = 32'h44; mem_req_ready = 1;
        @(negedge clk);
        chk("t5_to_valid", {31'b0, to_mem_req_valid}, 32'h1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mem_rsp_valid = 1; mem_rdata = 32'h12345678;
            end
            @(negedge clk);
            chk("t5_to_stall_wait", {31'b0, to_Stall}, 32'h1);
            chk("t5_to_buserr_wait", {31'b0, to_BusErr}, 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t5_to_buserr", {31'b0, to_BusErr}, 32'h1);
        chk("t5_to_stall_done", {31'b0, to_Stall}, 32'h0);
        chk("t5_to_instr_kept", to_Instr, 32'h00000013);
        chk("t5_dflt_instr", Instr, 32'h12345678);
        chk("t5_dflt_oldpc", OldPC, 32'h44);
        @(posedge clk); #1;
        IRWrite = 0;
        @(negedge clk);
        chk("t5_to_late_rsp", to_Instr, 32'h00000013);
        chk("t5_to_idle_valid", {31'b0, to_mem_req_valid}, 32'h0);
        @(posedge clk); #1;
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("t5_to_buserr_sticky", {31'b0, to_BusErr}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
